rf_write_scheduler: RTL and testbench

//  Sole owner of the register file write port (we3/ra3/wd3).

---
 rtl/rf_write_scheduler_pkg.sv | 34 +++
 rtl/rf_write_scheduler_if.sv | 47 ++++
 rtl/rr_arbiter2.sv | 39 +++
 rtl/rf_write_scheduler.sv | 84 ++++++++
 tb/tb_rf_write_scheduler.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/rf_write_scheduler_pkg.sv
// Shared widths, types and helpers for the register file write scheduler.
// The PC alias (R15) is an address, never a scoreboard or storage slot.
package rf_write_scheduler_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 15;

    typedef logic [ADDR_W-1:0]   reg_addr_t;
    typedef logic [DATA_W-1:0]   word_t;
    typedef logic [NUM_REGS-1:0] busy_t;

    localparam reg_addr_t REG_PC = 4'hF;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    function automatic logic reg_busy(busy_t b, reg_addr_t a);
        if (a == REG_PC) begin
            return 1'b0;
        end
        return b[a];
    endfunction

    function automatic busy_t reg_onehot(reg_addr_t a);
        if (a == REG_PC) begin
            return '0;
        end
        return busy_t'(1) << a;
    endfunction

endpackage

// File: rtl/rf_write_scheduler_if.sv
// Writeback sources, decode issue/check ports and the RF write port.
// The slave side is the scheduler; the master side is the pipeline.
interface rf_write_scheduler_if;
    import rf_write_scheduler_pkg::*;

    logic      alu_valid;
    logic      alu_ready;
    reg_addr_t alu_addr;
    word_t     alu_data;

    logic      mem_valid;
    logic      mem_ready;
    reg_addr_t mem_addr;
    word_t     mem_data;

    logic      issue_valid;
    logic      issue_ready;
    reg_addr_t issue_addr;

    reg_addr_t chk_ra1;
    reg_addr_t chk_ra2;
    logic      hazard;

    logic      rf_we;
    reg_addr_t rf_waddr;
    word_t     rf_wdata;
    logic      r15_wr_err;

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  issue_valid, issue_addr,
        input  chk_ra1, chk_ra2,
        output alu_ready, mem_ready, issue_ready, hazard,
        output rf_we, rf_waddr, rf_wdata, r15_wr_err
    );

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output issue_valid, issue_addr,
        output chk_ra1, chk_ra2,
        input  alu_ready, mem_ready, issue_ready, hazard,
        input  rf_we, rf_waddr, rf_wdata, r15_wr_err
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: req[0]=ALU, req[1]=MEM.
// On contention the source not granted last wins.
module rr_arbiter2
    import rf_write_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    src_e rr_last_q;
    src_e rr_last_d;

    always_comb begin
        gnt       = 2'b00;
        rr_last_d = rr_last_q;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (rr_last_q == SRC_MEM) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        if (gnt[0]) begin
            rr_last_d = SRC_ALU;
        end else if (gnt[1]) begin
            rr_last_d = SRC_MEM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q <= SRC_MEM;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/rf_write_scheduler.sv
// Sole owner of the RF write port: arbitrates ALU/MEM writeback,
// tracks pending destinations and absorbs writes to the PC alias.
module rf_write_scheduler
    import rf_write_scheduler_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    rf_write_scheduler_if.slave  bus
);

    logic [1:0] gnt;
    logic       any_gnt;
    reg_addr_t  g_addr;
    word_t      g_data;
    busy_t      clr_vec;
    busy_t      set_vec;

    busy_t      busy_q, busy_d;
    logic       we_q, we_d;
    reg_addr_t  waddr_q, waddr_d;
    word_t      wdata_q, wdata_d;
    logic       r15_q, r15_d;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({bus.mem_valid, bus.alu_valid}),
        .gnt   (gnt)
    );

    always_comb begin
        any_gnt = gnt[0] | gnt[1];
        g_addr  = gnt[1] ? bus.mem_addr : bus.alu_addr;
        g_data  = gnt[1] ? bus.mem_data : bus.alu_data;
        clr_vec = any_gnt ? reg_onehot(g_addr) : '0;
    end

    // A register retiring this cycle frees its slot for a new issue now,
    // but hazard still reports it until the RF write has landed.
    always_comb begin
        bus.issue_ready = !(reg_busy(busy_q, bus.issue_addr) &&
                            !reg_busy(clr_vec, bus.issue_addr));
        set_vec = (bus.issue_valid && bus.issue_ready)
                ? reg_onehot(bus.issue_addr) : '0;
        busy_d  = (busy_q & ~clr_vec) | set_vec;
        bus.hazard = reg_busy(busy_q, bus.chk_ra1) |
                     reg_busy(busy_q, bus.chk_ra2);
    end

    always_comb begin
        we_d    = any_gnt && (g_addr != REG_PC);
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (we_d) begin
            waddr_d = g_addr;
            wdata_d = g_data;
        end
        r15_d = r15_q | (any_gnt && (g_addr == REG_PC));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            r15_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            r15_q   <= r15_d;
        end
    end

    assign bus.alu_ready  = gnt[0];
    assign bus.mem_ready  = gnt[1];
    assign bus.rf_we      = we_q;
    assign bus.rf_waddr   = waddr_q;
    assign bus.rf_wdata   = wdata_q;
    assign bus.r15_wr_err = r15_q;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler: arbitration, write stage,
// scoreboard set/clear, R15 absorption and async reset.
module tb_rf_write_scheduler;
    import rf_write_scheduler_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    rf_write_scheduler_if ifc ();

    rf_write_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifc.alu_valid   = 1'b0;
        ifc.mem_valid   = 1'b0;
        ifc.issue_valid = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        idle();
        ifc.alu_addr   = '0;
        ifc.alu_data   = '0;
        ifc.mem_addr   = '0;
        ifc.mem_data   = '0;
        ifc.issue_addr = '0;
        ifc.chk_ra1    = '0;
        ifc.chk_ra2    = '0;
        step();
        step();
        check("rst_we", 32'(ifc.rf_we), 0);
        check("rst_waddr", 32'(ifc.rf_waddr), 0);
        check("rst_wdata", ifc.rf_wdata, 0);
        check("rst_err", 32'(ifc.r15_wr_err), 0);
        check("rst_haz", 32'(ifc.hazard), 0);
        rst_n = 1'b1;
        step();

        // contention: ALU first after reset, then alternate
        ifc.alu_valid = 1'b1;
        ifc.mem_valid = 1'b1;
        ifc.alu_addr  = 4'd1;
        ifc.mem_addr  = 4'd2;
        for (int i = 0; i < 4; i++) begin
            ifc.alu_data = 32'h100 + 32'(i);
            ifc.mem_data = 32'h200 + 32'(i);
            #1;
            check($sformatf("cont_alu_rdy%0d", i),
                  32'(ifc.alu_ready), (i % 2 == 0) ? 1 : 0);
            check($sformatf("cont_mem_rdy%0d", i),
                  32'(ifc.mem_ready), (i % 2 == 1) ? 1 : 0);
            step();
            check($sformatf("cont_we%0d", i), 32'(ifc.rf_we), 1);
            check($sformatf("cont_waddr%0d", i), 32'(ifc.rf_waddr),
                  (i % 2 == 0) ? 1 : 2);
            check($sformatf("cont_wdata%0d", i), ifc.rf_wdata,
                  (i % 2 == 0) ? 32'h100 + 32'(i) : 32'h200 + 32'(i));
        end
        idle();
        step();
        check("cont_idle_we", 32'(ifc.rf_we), 0);
        check("cont_hold_waddr", 32'(ifc.rf_waddr), 2);
        check("cont_hold_wdata", ifc.rf_wdata, 32'h203);

        // ALU only
        ifc.alu_valid = 1'b1;
        ifc.alu_addr  = 4'd3;
        ifc.alu_data  = 32'hDEADBEEF;
        #1;
        check("alu_rdy", 32'(ifc.alu_ready), 1);
        check("alu_mem_rdy", 32'(ifc.mem_ready), 0);
        step();
        idle();
        check("alu_we", 32'(ifc.rf_we), 1);
        check("alu_waddr", 32'(ifc.rf_waddr), 3);
        check("alu_wdata", ifc.rf_wdata, 32'hDEADBEEF);
        step();
        check("alu_we_drop", 32'(ifc.rf_we), 0);

        // scoreboard: issue r5, hazard, WAW stall, clear at grant
        ifc.issue_valid = 1'b1;
        ifc.issue_addr  = 4'd5;
        #1;
        check("sb_issue_rdy", 32'(ifc.issue_ready), 1);
        step();
        ifc.issue_valid = 1'b0;
        ifc.chk_ra1 = 4'd5;
        #1;
        check("sb_haz_ra1", 32'(ifc.hazard), 1);
        check("sb_waw", 32'(ifc.issue_ready), 0);
        ifc.mem_valid = 1'b1;
        ifc.mem_addr  = 4'd5;
        ifc.mem_data  = 32'h55;
        #1;
        check("sb_mem_rdy", 32'(ifc.mem_ready), 1);
        check("sb_clr_rdy", 32'(ifc.issue_ready), 1);
        check("sb_clr_haz", 32'(ifc.hazard), 1);
        step();
        idle();
        check("sb_haz_gone", 32'(ifc.hazard), 0);
        check("sb_we", 32'(ifc.rf_we), 1);
        check("sb_waddr", 32'(ifc.rf_waddr), 5);
        check("sb_wdata", ifc.rf_wdata, 32'h55);

        // same-cycle set and clear of r7: set wins
        ifc.issue_valid = 1'b1;
        ifc.issue_addr  = 4'd7;
        step();
        ifc.alu_valid = 1'b1;
        ifc.alu_addr  = 4'd7;
        ifc.alu_data  = 32'h77;
        #1;
        check("sc_rdy", 32'(ifc.issue_ready), 1);
        step();
        idle();
        ifc.chk_ra1 = 4'd7;
        #1;
        check("sc_busy", 32'(ifc.hazard), 1);
        check("sc_waddr", 32'(ifc.rf_waddr), 7);
        ifc.alu_valid = 1'b1;
        step();
        idle();
        check("sc_clear", 32'(ifc.hazard), 0);

        // R15 absorption
        ifc.alu_valid = 1'b1;
        ifc.alu_addr  = 4'hF;
        ifc.alu_data  = 32'hF00D;
        #1;
        check("r15_rdy", 32'(ifc.alu_ready), 1);
        step();
        idle();
        check("r15_we", 32'(ifc.rf_we), 0);
        check("r15_err", 32'(ifc.r15_wr_err), 1);
        check("r15_hold_waddr", 32'(ifc.rf_waddr), 7);
        ifc.chk_ra1 = 4'hF;
        ifc.issue_valid = 1'b1;
        ifc.issue_addr  = 4'hF;
        #1;
        check("r15_haz", 32'(ifc.hazard), 0);
        check("r15_issue_rdy", 32'(ifc.issue_ready), 1);
        step();
        ifc.issue_addr = 4'd9;
        step();
        idle();
        ifc.chk_ra2 = 4'd9;
        #1;
        check("haz_ra2", 32'(ifc.hazard), 1);
        check("r15_sticky", 32'(ifc.r15_wr_err), 1);

        // reset during an in-flight write
        ifc.alu_valid = 1'b1;
        ifc.alu_addr  = 4'd4;
        ifc.alu_data  = 32'h44;
        step();
        idle();
        check("pre_rst_we", 32'(ifc.rf_we), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", 32'(ifc.rf_we), 0);
        check("mid_rst_waddr", 32'(ifc.rf_waddr), 0);
        check("mid_rst_haz", 32'(ifc.hazard), 0);
        check("mid_rst_err", 32'(ifc.r15_wr_err), 0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_haz", 32'(ifc.hazard), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
